// File: rtl/rx_segment_tracker.sv
// rx_segment_tracker: maps voted segment bursts to frame-buffer writes and keeps per-frame sequence statistics
module rx_segment_tracker #(
    parameter int SEGMENT_NUM_MAX = 100,
    parameter int SEG_LEN = 1024,
    parameter int ADDR_W = 17
) (
    input  logic              clk125MHz,
    input  logic              reset,
    input  logic              en_in,
    input  logic [7:0]        data_in,
    input  logic [15:0]       seg_in,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              seg_done,
    output logic              seg_ok,
    output logic              frame_done,
    output logic [15:0]       frame_count,
    output logic [15:0]       lost_count,
    output logic [15:0]       dup_count,
    output logic [15:0]       len_err_count,
    output logic [15:0]       range_err_count
);
    localparam int SW = SEGMENT_NUM_MAX > 1 ? $clog2(SEGMENT_NUM_MAX) : 1;
    localparam int CW = $clog2(SEG_LEN + 2);
    localparam int RW = $clog2(SEGMENT_NUM_MAX + 1);
    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;
    state_t                     state_q, state_d;
    logic [SW-1:0]              cur_seg_q, cur_seg_d, last_seg_q, last_seg_d;
    logic [CW-1:0]              byte_cnt_q, byte_cnt_d;
    logic [RW-1:0]              rx_in_frame_q, rx_in_frame_d;
    logic [SEGMENT_NUM_MAX-1:0] bitmap_q, bitmap_d;
    logic                       range_bad_q, range_bad_d, first_seen_q, first_seen_d, blk_q, blk_d;
    logic                       wr_en_q, wr_en_d, seg_done_q, seg_done_d, seg_ok_q, seg_ok_d;
    logic                       frame_done_q, frame_done_d;
    logic [ADDR_W-1:0]          wr_addr_q, wr_addr_d;
    logic [7:0]                 wr_data_q, wr_data_d;
    logic [15:0]                frame_count_q, frame_count_d, lost_count_q, lost_count_d;
    logic [15:0]                dup_count_q, dup_count_d, len_err_count_q, len_err_count_d;
    logic [15:0]                range_err_count_q, range_err_count_d;
    logic [16:0]                lost_sum;
    logic                       start, dup, len_bad;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return v == 16'hFFFF ? v : v + 16'd1;
    endfunction

    assign lost_sum = {1'b0, lost_count_q} + 17'(SEGMENT_NUM_MAX) - 17'(rx_in_frame_q);
    assign start = en_in && !blk_q && state_q != RECV;

    always_comb begin
        state_d = state_q;
        cur_seg_d = cur_seg_q;
        last_seg_d = last_seg_q;
        byte_cnt_d = byte_cnt_q;
        rx_in_frame_d = rx_in_frame_q;
        bitmap_d = bitmap_q;
        range_bad_d = range_bad_q;
        first_seen_d = first_seen_q;
        blk_d = blk_q && en_in;
        wr_en_d = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = data_in;
        seg_done_d = 1'b0;
        seg_ok_d = 1'b0;
        frame_done_d = 1'b0;
        frame_count_d = frame_count_q;
        lost_count_d = lost_count_q;
        dup_count_d = dup_count_q;
        len_err_count_d = len_err_count_q;
        range_err_count_d = range_err_count_q;
        dup = 1'b0;
        len_bad = 1'b0;
        if (state_q == CHECK) begin
            seg_done_d = 1'b1;
            if (range_bad_q) begin
                range_err_count_d = sat_inc(range_err_count_q);
            end else begin
                if (first_seen_q && cur_seg_q < last_seg_q) begin
                    frame_done_d = 1'b1;
                    frame_count_d = frame_count_q + 16'd1;
                    lost_count_d = lost_sum[16] ? 16'hFFFF : lost_sum[15:0];
                    bitmap_d = '0;
                    rx_in_frame_d = '0;
                end
                dup = bitmap_d[cur_seg_q];
                if (dup) begin
                    dup_count_d = sat_inc(dup_count_q);
                end else begin
                    bitmap_d[cur_seg_q] = 1'b1;
                    rx_in_frame_d = rx_in_frame_d + RW'(1);
                end
                len_bad = byte_cnt_q != CW'(SEG_LEN);
                len_err_count_d = len_bad ? sat_inc(len_err_count_q) : len_err_count_q;
                seg_ok_d = !dup && !len_bad;
                last_seg_d = cur_seg_q;
                first_seen_d = 1'b1;
            end
        end
        // A burst may start in CHECK; the previous burst's check above still completes.
        if (start) begin
            state_d = RECV;
            cur_seg_d = SW'(seg_in);
            byte_cnt_d = CW'(1);
            range_bad_d = seg_in >= 16'(SEGMENT_NUM_MAX);
            wr_en_d = !(seg_in >= 16'(SEGMENT_NUM_MAX));
            wr_addr_d = ADDR_W'(32'(seg_in) * 32'(SEG_LEN));
        end else if (state_q == RECV) begin
            state_d = en_in ? RECV : CHECK;
            byte_cnt_d = (!en_in || byte_cnt_q == CW'(SEG_LEN + 1)) ? byte_cnt_q : byte_cnt_q + CW'(1);
            wr_en_d = en_in && byte_cnt_q < CW'(SEG_LEN) && !range_bad_q;
            wr_addr_d = ADDR_W'(32'(cur_seg_q) * 32'(SEG_LEN) + 32'(byte_cnt_q));
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk125MHz) begin
        if (reset) begin
            state_q <= IDLE;
            cur_seg_q <= '0;
            last_seg_q <= '0;
            byte_cnt_q <= '0;
            rx_in_frame_q <= '0;
            bitmap_q <= '0;
            range_bad_q <= 1'b0;
            first_seen_q <= 1'b0;
            blk_q <= 1'b1;
            wr_en_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            seg_done_q <= 1'b0;
            seg_ok_q <= 1'b0;
            frame_done_q <= 1'b0;
            frame_count_q <= '0;
            lost_count_q <= '0;
            dup_count_q <= '0;
            len_err_count_q <= '0;
            range_err_count_q <= '0;
        end else begin
            state_q <= state_d;
            cur_seg_q <= cur_seg_d;
            last_seg_q <= last_seg_d;
            byte_cnt_q <= byte_cnt_d;
            rx_in_frame_q <= rx_in_frame_d;
            bitmap_q <= bitmap_d;
            range_bad_q <= range_bad_d;
            first_seen_q <= first_seen_d;
            blk_q <= blk_d;
            wr_en_q <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            seg_done_q <= seg_done_d;
            seg_ok_q <= seg_ok_d;
            frame_done_q <= frame_done_d;
            frame_count_q <= frame_count_d;
            lost_count_q <= lost_count_d;
            dup_count_q <= dup_count_d;
            len_err_count_q <= len_err_count_d;
            range_err_count_q <= range_err_count_d;
        end
    end

    assign wr_en = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign seg_done = seg_done_q;
    assign seg_ok = seg_ok_q;
    assign frame_done = frame_done_q;
    assign frame_count = frame_count_q;
    assign lost_count = lost_count_q;
    assign dup_count = dup_count_q;
    assign len_err_count = len_err_count_q;
    assign range_err_count = range_err_count_q;
endmodule

// File: tb/tb_rx_segment_tracker.sv
// tb_rx_segment_tracker: directed-vector bench for rx_segment_tracker
module tb_rx_segment_tracker;
    localparam int NSEG = 4, SLEN = 8, AW = 5;
    logic          clk = 1'b0, reset = 1'b1, en_in = 1'b0;
    logic [7:0]    data_in = '0;
    logic [15:0]   seg_in = '0;
    logic          wr_en, seg_done, seg_ok, frame_done;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [15:0]   frame_count, lost_count, dup_count, len_err_count, range_err_count;
    int            n_chk = 0, n_err = 0, sd = 0, okc = 0, fd = 0, lat_bad = 0;
    logic [12:0]   wq[$];
    int            eq[$];

    rx_segment_tracker #(.SEGMENT_NUM_MAX(NSEG), .SEG_LEN(SLEN), .ADDR_W(AW)) dut (
        .clk125MHz(clk), .reset(reset), .en_in(en_in), .data_in(data_in), .seg_in(seg_in),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .seg_done(seg_done), .seg_ok(seg_ok),
        .frame_done(frame_done), .frame_count(frame_count), .lost_count(lost_count),
        .dup_count(dup_count), .len_err_count(len_err_count), .range_err_count(range_err_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en) begin
            wq.push_back({wr_addr, wr_data});
            if (!en_in) lat_bad++;
        end
        if (seg_done) begin
            sd++;
            if (seg_ok) okc++;
        end
        if (frame_done) fd++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic clr;
        wq.delete();
        eq.delete();
        sd = 0;
        okc = 0;
        fd = 0;
        lat_bad = 0;
    endtask

    task automatic do_reset;
        step;
        reset = 1'b1;
        en_in = 1'b0;
        step;
        reset = 1'b0;
        step;
    endtask

    task automatic send(input int seg, input int len);
        for (int i = 0; i < len; i++) begin
            step;
            en_in = 1'b1;
            seg_in = (i == 0) ? 16'(seg) : 16'hAAAA;
            data_in = 8'(seg * SLEN + i);
        end
        step;
        en_in = 1'b0;
        repeat (4) step;
    endtask

    task automatic expw(input int a, input int n);
        for (int i = 0; i < n; i++) eq.push_back(a + i);
    endtask

    task automatic check_wr(input string tag);
        check({tag, "_nwr"}, wq.size(), eq.size());
        for (int i = 0; i < wq.size() && i < eq.size(); i++)
            check({tag, "_wr"}, 32'(wq[i]), 32'({5'(eq[i]), 8'(eq[i])}));
        check({tag, "_lat"}, lat_bad, 0);
    endtask

    task automatic check_ev(input string tag, input int s, input int o, input int f);
        check({tag, "_segdone"}, sd, s);
        check({tag, "_segok"}, okc, o);
        check({tag, "_framedone"}, fd, f);
    endtask

    task automatic check_cnt(input string tag, input int fc, input int lc, input int dc, input int le, input int re);
        check({tag, "_frame_cnt"}, frame_count, fc);
        check({tag, "_lost_cnt"}, lost_count, lc);
        check({tag, "_dup_cnt"}, dup_count, dc);
        check({tag, "_len_cnt"}, len_err_count, le);
        check({tag, "_range_cnt"}, range_err_count, re);
    endtask

    initial begin
        repeat (2) step;
        reset = 1'b0;
        step;
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_seg_done", seg_done, 0);
        check("rst_frame_done", frame_done, 0);
        check_cnt("rst", 0, 0, 0, 0, 0);

        clr;
        send(0, 8); send(1, 8); send(2, 8); send(3, 8); send(0, 8);
        expw(0, 32); expw(0, 8);
        check_wr("t1");
        check_ev("t1", 5, 5, 1);
        check_cnt("t1", 1, 0, 0, 0, 0);

        do_reset; clr;
        send(0, 8); send(2, 8); send(3, 8); send(1, 8);
        check("t2_wrap_frame", frame_count, 1);
        check("t2_wrap_lost", lost_count, 1);
        send(1, 8);
        expw(0, 8); expw(16, 8); expw(24, 8); expw(8, 8); expw(8, 8);
        check_wr("t2");
        check_ev("t2", 5, 4, 1);
        check_cnt("t2", 1, 1, 1, 0, 0);

        do_reset; clr;
        send(1, 8); send(1, 8);
        expw(8, 8); expw(8, 8);
        check_wr("t3");
        check_ev("t3", 2, 1, 0);
        check_cnt("t3", 0, 0, 1, 0, 0);

        do_reset; clr;
        send(2, 11); send(3, 5);
        expw(16, 8); expw(24, 5);
        check_wr("t4");
        check_ev("t4", 2, 0, 0);
        check_cnt("t4", 0, 0, 0, 2, 0);

        do_reset; clr;
        send(1, 8); send(7, 8); send(2, 8);
        expw(8, 8); expw(16, 8);
        check_wr("t5");
        check_ev("t5", 3, 2, 0);
        check_cnt("t5", 0, 0, 0, 0, 1);

        for (int i = 0; i < 4; i++) begin
            step;
            en_in = 1'b1;
            seg_in = (i == 0) ? 16'd0 : 16'hAAAA;
            data_in = 8'(i);
        end
        step;
        reset = 1'b1;
        data_in = 8'd4;
        step;
        reset = 1'b0;
        clr;
        for (int i = 0; i < 3; i++) begin
            step;
            data_in = 8'(5 + i);
        end
        step;
        en_in = 1'b0;
        repeat (4) step;
        check_wr("t6_abort");
        check_ev("t6_abort", 0, 0, 0);
        check_cnt("t6_abort", 0, 0, 0, 0, 0);
        clr;
        send(0, 8);
        expw(0, 8);
        check_wr("t6_clean");
        check_ev("t6_clean", 1, 1, 0);
        check_cnt("t6_clean", 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
